fifo_req_issuer: RTL and testbench

Drains request words from the test FIFO and issues them as memory requests to the Lease Cache memory controller under test. Sits directly downstream of the FIFO: it drives the FIFO read enable, captures the popped word, splits it into op and address, and presents it on a valid/ready request port. It tracks outstanding requests against controller responses, throttling when a limit is reached and counting issued requests for the bench.

---
 rtl/lease_tb_pkg.sv | 19 +
 rtl/fifo_req_issuer_if.sv | 33 +++
 rtl/fifo_req_issuer.sv | 81 ++++++++
 tb/tb_fifo_req_issuer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/lease_tb_pkg.sv
// rtl/lease_tb_pkg.sv - state and op encodings shared by issuer, FIFO loader and scoreboard
package lease_tb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    READ    = 2'b01,
    CAPTURE = 2'b10,
    ISSUE   = 2'b11
  } state_t;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  // The op bit is always the MSB of a FIFO word; the rest is address.
  function automatic int op_pos(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/fifo_req_issuer_if.sv
// rtl/fifo_req_issuer_if.sv - FIFO-side and controller-side signals of the request issuer
interface fifo_req_issuer_if #(
  parameter int width           = 8,
  parameter int max_outstanding = 4
);
  localparam int ow = $clog2(max_outstanding) + 1;

  logic             fifo_empty_i;
  logic [width-1:0] fifo_dout_i;
  logic             fifo_rd_en_o;
  logic             req_valid_o;
  logic             req_ready_i;
  logic             req_we_o;
  logic [width-2:0] req_addr_o;
  logic             rsp_valid_i;
  logic [15:0]      issued_cnt_o;
  logic [ow-1:0]    outstanding_o;
  logic             busy_o;
  logic             err_o;

  modport slave (
    input  fifo_empty_i, fifo_dout_i, req_ready_i, rsp_valid_i,
    output fifo_rd_en_o, req_valid_o, req_we_o, req_addr_o,
           issued_cnt_o, outstanding_o, busy_o, err_o
  );

  modport master (
    output fifo_empty_i, fifo_dout_i, req_ready_i, rsp_valid_i,
    input  fifo_rd_en_o, req_valid_o, req_we_o, req_addr_o,
           issued_cnt_o, outstanding_o, busy_o, err_o
  );

endinterface

// File: rtl/fifo_req_issuer.sv
// rtl/fifo_req_issuer.sv - pops FIFO words and issues them as throttled memory requests
module fifo_req_issuer
  import lease_tb_pkg::*;
#(
  parameter int width           = 8,
  parameter int max_outstanding = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  fifo_req_issuer_if.slave   bus
);

  localparam int            ow      = $clog2(max_outstanding) + 1;
  localparam int            op_bit  = op_pos(width);
  localparam logic [ow-1:0] max_cnt = ow'(max_outstanding);

  state_t           state, state_next;
  logic             we_q;
  logic [width-2:0] addr_q;
  logic [15:0]      issued_q;
  logic [ow-1:0]    outst_q, outst_next;
  logic             err_q;
  logic             hs;
  logic             rsp_err;

  always_comb begin
    hs         = (state == ISSUE) && bus.req_ready_i;
    outst_next = outst_q;
    rsp_err    = 1'b0;
    case ({hs, bus.rsp_valid_i})
      2'b10: outst_next = outst_q + ow'(1);
      2'b01: begin
        // A response with nothing in flight is flagged, never counted.
        if (outst_q == '0) rsp_err = 1'b1;
        else               outst_next = outst_q - ow'(1);
      end
      default: ;
    endcase

    state_next = state;
    case (state)
      IDLE:    if (!bus.fifo_empty_i && (outst_q < max_cnt)) state_next = READ;
      READ:    state_next = CAPTURE;
      CAPTURE: state_next = ISSUE;
      ISSUE: begin
        if (hs) state_next = (!bus.fifo_empty_i && (outst_next < max_cnt)) ? READ : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      issued_q <= '0;
      outst_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state   <= state_next;
      outst_q <= outst_next;
      if (hs)      issued_q <= issued_q + 16'd1;
      if (rsp_err) err_q    <= 1'b1;
      if (state == CAPTURE) begin
        we_q   <= bus.fifo_dout_i[op_bit];
        addr_q <= bus.fifo_dout_i[width-2:0];
      end
    end
  end

  assign bus.fifo_rd_en_o  = (state == READ);
  assign bus.req_valid_o   = (state == ISSUE);
  assign bus.req_we_o      = we_q;
  assign bus.req_addr_o    = addr_q;
  assign bus.issued_cnt_o  = issued_q;
  assign bus.outstanding_o = outst_q;
  assign bus.busy_o        = (state != IDLE) || (outst_q != '0);
  assign bus.err_o         = err_q;

endmodule

// File: tb/tb_fifo_req_issuer.sv
// tb/tb_fifo_req_issuer.sv - directed-vector bench for fifo_req_issuer with a queue-backed FIFO model
module tb_fifo_req_issuer;
  import lease_tb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_req_issuer_if #(.width(8), .max_outstanding(4)) bus ();

  fifo_req_issuer #(.width(8), .max_outstanding(4)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus.slave)
  );

  logic [7:0] fifo_q[$];
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_empty = 1'b1;
  int         rd_cnt = 0;
  int         hs_cnt = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         rd_snap;
  int         hs_snap;

  assign bus.fifo_empty_i = fifo_empty;
  assign bus.fifo_dout_i  = fifo_dout;

  always @(posedge clk) begin
    if (bus.fifo_rd_en_o) begin
      rd_cnt++;
      if (fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
    end
    if (bus.req_valid_o && bus.req_ready_i) hs_cnt++;
  end

  // Empty flag settles shortly after either clock edge, well before the next posedge.
  always begin
    @(clk);
    #1;
    fifo_empty = (fifo_q.size() == 0);
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_req(input string tag, input logic we, input logic [6:0] addr);
    check_vec({tag, "_valid"}, 32'(bus.req_valid_o), 32'd1);
    check_vec({tag, "_we"},    32'(bus.req_we_o),    32'(we));
    check_vec({tag, "_addr"},  32'(bus.req_addr_o),  32'(addr));
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.req_ready_i = 1'b0;
    bus.rsp_valid_i = 1'b0;
    fifo_q.push_back(8'h25);

    // Reset held with FIFO non-empty
    tick(2);
    check_vec("rst_valid",  32'(bus.req_valid_o),   32'd0);
    check_vec("rst_rd_en",  32'(bus.fifo_rd_en_o),  32'd0);
    check_vec("rst_we",     32'(bus.req_we_o),      32'd0);
    check_vec("rst_addr",   32'(bus.req_addr_o),    32'd0);
    check_vec("rst_issued", 32'(bus.issued_cnt_o),  32'd0);
    check_vec("rst_outst",  32'(bus.outstanding_o), 32'd0);
    check_vec("rst_busy",   32'(bus.busy_o),        32'd0);
    check_vec("rst_err",    32'(bus.err_o),         32'd0);
    check_vec("rst_nopop",  32'(rd_cnt),            32'd0);

    // Single read of 8'h25
    rst_n           = 1'b1;
    bus.req_ready_i = 1'b1;
    tick();
    check_vec("rd_rd_en", 32'(bus.fifo_rd_en_o), 32'd1);
    tick(2);
    check_req("rd", OP_RD, 7'h25);
    tick();
    check_vec("rd_issued", 32'(bus.issued_cnt_o),  32'd1);
    check_vec("rd_outst",  32'(bus.outstanding_o), 32'd1);
    check_vec("rd_busy",   32'(bus.busy_o),        32'd1);
    check_vec("rd_done",   32'(bus.req_valid_o),   32'd0);
    bus.rsp_valid_i = 1'b1;
    tick();
    bus.rsp_valid_i = 1'b0;
    check_vec("rsp_outst", 32'(bus.outstanding_o), 32'd0);
    check_vec("rsp_busy",  32'(bus.busy_o),        32'd0);

    // Backpressure on 8'hC3 with further words waiting
    bus.req_ready_i = 1'b0;
    fifo_q.push_back(8'hC3);
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h92);
    tick(3);
    check_req("bp_first", OP_WR, 7'h43);
    rd_snap = rd_cnt;
    hs_snap = hs_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_req("bp_hold", OP_WR, 7'h43);
    end
    check_vec("bp_no_pop", 32'(rd_cnt), 32'(rd_snap));
    bus.req_ready_i = 1'b1;
    tick();
    check_vec("bp_one_hs",  32'(hs_cnt - hs_snap),   32'd1);
    check_vec("bp_issued",  32'(bus.issued_cnt_o),   32'd2);
    check_vec("bp_outst",   32'(bus.outstanding_o),  32'd1);
    check_vec("bp_reread",  32'(bus.fifo_rd_en_o),   32'd1);

    // Word 8'h11, then simultaneous handshake/response on 8'h92 at outstanding=2
    tick(2);
    check_req("w11", OP_RD, 7'h11);
    tick();
    check_vec("w11_outst", 32'(bus.outstanding_o), 32'd2);
    tick(2);
    check_req("w92", OP_WR, 7'h12);
    bus.rsp_valid_i = 1'b1;
    tick();
    bus.rsp_valid_i = 1'b0;
    check_vec("sim_outst",  32'(bus.outstanding_o), 32'd2);
    check_vec("sim_issued", 32'(bus.issued_cnt_o),  32'd4);
    check_vec("sim_idle",   32'(bus.req_valid_o),   32'd0);
    bus.rsp_valid_i = 1'b1;
    tick(2);
    bus.rsp_valid_i = 1'b0;
    check_vec("drain_outst", 32'(bus.outstanding_o), 32'd0);
    check_vec("drain_err",   32'(bus.err_o),         32'd0);

    // Spurious response at zero outstanding
    bus.rsp_valid_i = 1'b1;
    tick();
    bus.rsp_valid_i = 1'b0;
    check_vec("spur_err",   32'(bus.err_o),         32'd1);
    check_vec("spur_outst", 32'(bus.outstanding_o), 32'd0);
    check_vec("spur_busy",  32'(bus.busy_o),        32'd0);

    // Throttle: six words, no responses, limit of four
    for (int i = 1; i <= 6; i++) fifo_q.push_back(8'(i));
    tick(20);
    check_vec("thr_issued", 32'(bus.issued_cnt_o),  32'd8);
    check_vec("thr_outst",  32'(bus.outstanding_o), 32'd4);
    check_vec("thr_left",   32'(fifo_q.size()),     32'd2);
    check_vec("thr_busy",   32'(bus.busy_o),        32'd1);
    rd_snap = rd_cnt;
    tick(4);
    check_vec("thr_stay",   32'(rd_cnt),            32'(rd_snap));
    check_vec("thr_novalid", 32'(bus.req_valid_o),  32'd0);
    bus.rsp_valid_i = 1'b1;
    tick();
    bus.rsp_valid_i = 1'b0;
    check_vec("thr_rsp_outst", 32'(bus.outstanding_o), 32'd3);
    check_vec("thr_rsp_idle",  32'(bus.fifo_rd_en_o),  32'd0);
    tick();
    check_vec("thr_resume", 32'(bus.fifo_rd_en_o), 32'd1);
    tick(2);
    check_req("thr_5th", OP_RD, 7'h05);
    bus.req_ready_i = 1'b0;
    tick();
    bus.req_ready_i = 1'b1;
    tick();
    check_vec("thr_5th_issued", 32'(bus.issued_cnt_o),  32'd9);
    check_vec("thr_5th_outst",  32'(bus.outstanding_o), 32'd4);

    // Reset while the 6th request is stalled in ISSUE
    bus.req_ready_i = 1'b0;
    bus.rsp_valid_i = 1'b1;
    tick();
    bus.rsp_valid_i = 1'b0;
    tick(3);
    check_req("mid_6th", OP_RD, 7'h06);
    rst_n = 1'b0;
    tick();
    check_vec("mid_valid",  32'(bus.req_valid_o),   32'd0);
    check_vec("mid_issued", 32'(bus.issued_cnt_o),  32'd0);
    check_vec("mid_outst",  32'(bus.outstanding_o), 32'd0);
    check_vec("mid_err",    32'(bus.err_o),         32'd0);
    check_vec("mid_busy",   32'(bus.busy_o),        32'd0);
    fifo_q.push_back(8'hA7);
    tick();
    rst_n           = 1'b1;
    bus.req_ready_i = 1'b1;
    tick();
    check_vec("post_rd_en", 32'(bus.fifo_rd_en_o), 32'd1);
    tick(2);
    check_req("post", OP_WR, 7'h27);
    tick();
    check_vec("post_issued", 32'(bus.issued_cnt_o),  32'd1);
    check_vec("post_outst",  32'(bus.outstanding_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
